filter_output_scheduler: RTL and testbench

//  Shares the single serial DAC between four 12-bit Avalon-ST sample streams:
//  raw ADC, lowpass, highpass and bandpass (bandpass pre-truncated to 12 bits).

---
 rtl/filter_output_scheduler_if.sv | 41 ++++
 rtl/filter_output_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_filter_output_scheduler.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_output_scheduler_if.sv
// Sample-stream bundle between the four filter sinks, the scheduler and the DAC source.
interface filter_output_scheduler_if #(
    parameter int DATA_WIDTH = 12
) ();
    logic [DATA_WIDTH-1:0] sink0_data;
    logic                  sink0_valid;
    logic [1:0]            sink0_error;
    logic [DATA_WIDTH-1:0] sink1_data;
    logic                  sink1_valid;
    logic [1:0]            sink1_error;
    logic [DATA_WIDTH-1:0] sink2_data;
    logic                  sink2_valid;
    logic [1:0]            sink2_error;
    logic [DATA_WIDTH-1:0] sink3_data;
    logic                  sink3_valid;
    logic [1:0]            sink3_error;
    logic                  source_ready;
    logic [DATA_WIDTH-1:0] source_data;
    logic                  source_valid;
    logic [1:0]            source_error;

    // Producer side: filter streams and the DAC ready line.
    modport master (
        output sink0_data, sink0_valid, sink0_error,
        output sink1_data, sink1_valid, sink1_error,
        output sink2_data, sink2_valid, sink2_error,
        output sink3_data, sink3_valid, sink3_error,
        output source_ready,
        input  source_data, source_valid, source_error
    );

    // Scheduler side.
    modport slave (
        input  sink0_data, sink0_valid, sink0_error,
        input  sink1_data, sink1_valid, sink1_error,
        input  sink2_data, sink2_valid, sink2_error,
        input  sink3_data, sink3_valid, sink3_error,
        input  source_ready,
        output source_data, source_valid, source_error
    );
endinterface

// File: rtl/filter_output_scheduler.sv
// Shares one serial DAC between four sample streams: debounced channel select,
// one-sample buffer on the active stream, paced issue with post-switch muting.
//
// state  | meaning
// IDLE   | wait for a pending channel change or a buffered sample with DAC ready
// ISSUE  | source_valid high for this one cycle; settle counter steps down
// GAP    | one idle cycle so the DAC can drop ready
// SWITCH | apply the debounced select, flush the buffer, restart settling
//
// The buffered sample is handed to the output register on the edge that
// leaves IDLE, so that edge is where the buffer drains; a capture landing in
// that same cycle is kept and is not an overrun.
module filter_output_scheduler #(
    parameter int                  DATA_WIDTH      = 12,
    parameter int                  DB_WIDTH        = 18,
    parameter int                  DEBOUNCE_CYCLES = 200000,
    parameter int                  SETTLE_SAMPLES  = 64,
    parameter logic [DATA_WIDTH-1:0] MUTE_CODE     = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [1:0]                 sel_async,
    filter_output_scheduler_if.slave   st,
    output logic [1:0]                 active_sel,
    output logic                       muting,
    output logic [7:0]                 overrun_count
);
    localparam int SW = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [DB_WIDTH-1:0] DB_MAX     = DB_WIDTH'(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0]       SETTLE_MAX = SW'(SETTLE_SAMPLES);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, SWITCH} state_t;

    state_t                state_q;
    logic [1:0]            active_sel_q;
    logic [SW-1:0]         settle_q;
    logic [DATA_WIDTH-1:0] source_data_q;
    logic                  source_valid_q;
    logic [1:0]            source_error_q;

    logic [1:0]            sel_meta_q, sel_meta_d;
    logic [1:0]            sel_sync_q, sel_sync_d;
    logic [1:0]            cand_q, cand_d;
    logic [DB_WIDTH-1:0]   db_cnt_q, db_cnt_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [1:0]            buf_err_q, buf_err_d;
    logic                  full_q, full_d;
    logic [7:0]            overrun_q, overrun_d;

    logic                  cap_valid;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [1:0]            cap_err;
    logic                  db_done;
    logic                  pending;
    logic                  drain;
    logic                  capture;

    // Select the sink stream of the currently applied channel.
    always_comb begin
        cap_valid = 1'b0;
        cap_data  = st.sink0_data;
        cap_err   = st.sink0_error;
        case (active_sel_q)
            2'd0: begin
                cap_valid = st.sink0_valid;
                cap_data  = st.sink0_data;
                cap_err   = st.sink0_error;
            end
            2'd1: begin
                cap_valid = st.sink1_valid;
                cap_data  = st.sink1_data;
                cap_err   = st.sink1_error;
            end
            2'd2: begin
                cap_valid = st.sink2_valid;
                cap_data  = st.sink2_data;
                cap_err   = st.sink2_error;
            end
            default: begin
                cap_valid = st.sink3_valid;
                cap_data  = st.sink3_data;
                cap_err   = st.sink3_error;
            end
        endcase
    end

    assign db_done = (db_cnt_q == DB_MAX);
    assign pending = db_done && (cand_q != active_sel_q);
    assign drain   = (state_q == IDLE) && !pending && full_q && st.source_ready;
    // Samples arriving while the channel is being switched belong to the old stream.
    assign capture = cap_valid && (state_q != SWITCH);

    // Next-state for synchroniser, debounce, sample buffer and overrun counter.
    always_comb begin
        sel_meta_d = sel_async;
        sel_sync_d = sel_meta_q;
        cand_d     = cand_q;
        db_cnt_d   = db_cnt_q;
        if (sel_sync_q != cand_q) begin
            cand_d   = sel_sync_q;
            db_cnt_d = '0;
        end else if (!db_done) begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        buf_d     = buf_q;
        buf_err_d = buf_err_q;
        full_d    = full_q;
        overrun_d = overrun_q;
        if (state_q == SWITCH) begin
            full_d = 1'b0;
        end else if (capture) begin
            buf_d     = cap_data;
            buf_err_d = cap_err;
            full_d    = 1'b1;
            if (full_q && !drain && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // Register the datapath next-state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_meta_q <= '0;
            sel_sync_q <= '0;
            cand_q     <= '0;
            db_cnt_q   <= '0;
            buf_q      <= '0;
            buf_err_q  <= '0;
            full_q     <= 1'b0;
            overrun_q  <= '0;
        end else begin
            sel_meta_q <= sel_meta_d;
            sel_sync_q <= sel_sync_d;
            cand_q     <= cand_d;
            db_cnt_q   <= db_cnt_d;
            buf_q      <= buf_d;
            buf_err_q  <= buf_err_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
        end
    end

    // Issue sequencing with registered DAC outputs, channel apply and settle count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            active_sel_q   <= '0;
            settle_q       <= SETTLE_MAX;
            source_data_q  <= MUTE_CODE;
            source_valid_q <= 1'b0;
            source_error_q <= '0;
        end else begin
            source_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending) begin
                        state_q <= SWITCH;
                    end else if (full_q && st.source_ready) begin
                        state_q        <= ISSUE;
                        source_valid_q <= 1'b1;
                        source_error_q <= buf_err_q;
                        source_data_q  <= ((settle_q != '0) || (buf_err_q != 2'b00))
                                          ? MUTE_CODE : buf_q;
                    end
                end
                ISSUE: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - 1'b1;
                    end
                    state_q <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                SWITCH: begin
                    active_sel_q <= cand_q;
                    settle_q     <= SETTLE_MAX;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign st.source_data  = source_data_q;
    assign st.source_valid = source_valid_q;
    assign st.source_error = source_error_q;
    assign active_sel      = active_sel_q;
    assign muting          = (settle_q != '0);
    assign overrun_count   = overrun_q;
endmodule

// File: tb/tb_filter_output_scheduler.sv
// Bench for filter_output_scheduler: directed scenarios plus random traffic,
// all cycles compared against a behavioural model of the scheduling rules.
module tb_filter_output_scheduler;
    localparam int DBC = 40;
    localparam int SET = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] sel_async = 2'd0;
    logic [1:0] active_sel;
    logic       muting;
    logic [7:0] overrun_count;

    int checks = 0;
    int errors = 0;

    filter_output_scheduler_if #(.DATA_WIDTH(12)) bus ();

    filter_output_scheduler #(
        .DATA_WIDTH(12), .DB_WIDTH(8), .DEBOUNCE_CYCLES(DBC),
        .SETTLE_SAMPLES(SET), .MUTE_CODE(12'h000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sel_async(sel_async), .st(bus),
        .active_sel(active_sel), .muting(muting), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [1:0]  m_s1, m_s2, m_cand, m_act;
    int          m_cnt, m_settle, m_ovr, m_busy;
    bit          m_full, m_switch_due, m_out_valid;
    logic [11:0] m_buf, m_out_data;
    logic [1:0]  m_berr, m_out_err;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_cand = 0; m_act = 0; m_cnt = 0;
        m_settle = SET; m_ovr = 0; m_busy = 0;
        m_full = 0; m_switch_due = 0; m_out_valid = 0;
        m_buf = 0; m_berr = 0; m_out_data = 0; m_out_err = 0;
    endtask

    task automatic sink_of(input logic [1:0] ch, output bit v, output logic [11:0] d,
                           output logic [1:0] e);
        case (ch)
            2'd0: begin v = bus.sink0_valid; d = bus.sink0_data; e = bus.sink0_error; end
            2'd1: begin v = bus.sink1_valid; d = bus.sink1_data; e = bus.sink1_error; end
            2'd2: begin v = bus.sink2_valid; d = bus.sink2_data; e = bus.sink2_error; end
            default: begin v = bus.sink3_valid; d = bus.sink3_data; e = bus.sink3_error; end
        endcase
    endtask

    task automatic model_step();
        bit pending, do_switch, just_issued, drain, cv;
        logic [11:0] cd;
        logic [1:0] ce;
        pending     = (m_cnt == DBC) && (m_cand != m_act);
        do_switch   = m_switch_due;
        just_issued = m_out_valid;
        sink_of(m_act, cv, cd, ce);
        drain = 0;
        m_out_valid = 0;
        m_switch_due = 0;
        // every issued sample, clean or not, counts toward settling as it leaves
        if (just_issued && m_settle > 0) m_settle--;
        if (do_switch) begin
            m_act = m_cand;
            m_settle = SET;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (pending) begin
            m_switch_due = 1;
        end else if (m_full && bus.source_ready) begin
            m_out_valid = 1;
            m_out_data  = (m_settle != 0 || m_berr != 0) ? 12'h000 : m_buf;
            m_out_err   = m_berr;
            drain = 1;
            m_busy = 2;
        end
        if (do_switch) m_full = 0;
        else if (cv) begin
            if (m_full && !drain && m_ovr < 255) m_ovr++;
            m_buf = cd; m_berr = ce; m_full = 1;
        end else if (drain) m_full = 0;
        if (m_s2 != m_cand) begin
            m_cand = m_s2; m_cnt = 0;
        end else if (m_cnt < DBC) m_cnt++;
        m_s2 = m_s1;
        m_s1 = sel_async;
    endtask

    // Cycle compare of every DUT output against the model.
    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else model_step();
        #1;
        checks++;
        if (bus.source_valid !== m_out_valid || bus.source_data !== m_out_data ||
            bus.source_error !== m_out_err || active_sel !== m_act ||
            muting !== (m_settle != 0) || overrun_count !== 8'(m_ovr)) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got v=%0b d=%h e=%0d sel=%0d mute=%0b ovr=%0d exp v=%0b d=%h e=%0d sel=%0d mute=%0b ovr=%0d",
                     $time, bus.source_valid, bus.source_data, bus.source_error, active_sel,
                     muting, overrun_count, m_out_valid, m_out_data, m_out_err, m_act,
                     m_settle != 0, m_ovr);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_sink(input logic [1:0] ch, input bit v, input logic [11:0] d,
                            input logic [1:0] e);
        case (ch)
            2'd0: begin bus.sink0_valid = v; bus.sink0_data = d; bus.sink0_error = e; end
            2'd1: begin bus.sink1_valid = v; bus.sink1_data = d; bus.sink1_error = e; end
            2'd2: begin bus.sink2_valid = v; bus.sink2_data = d; bus.sink2_error = e; end
            default: begin bus.sink3_valid = v; bus.sink3_data = d; bus.sink3_error = e; end
        endcase
    endtask

    task automatic send(input logic [1:0] ch, input logic [11:0] d, input logic [1:0] e);
        @(negedge clk);
        set_sink(ch, 1'b1, d, e);
        @(negedge clk);
        set_sink(ch, 1'b0, d, e);
    endtask

    // One sample in, expect its issue exactly two cycles after the pulse.
    task automatic issue_check(input string name, input logic [1:0] ch, input logic [11:0] d,
                               input logic [1:0] e, input int exp_d, input int exp_e,
                               input int exp_mute);
        send(ch, d, e);
        @(posedge clk);
        #1;
        chk({name, "_valid"}, int'(bus.source_valid), 1);
        chk({name, "_data"}, int'(bus.source_data), exp_d);
        chk({name, "_err"}, int'(bus.source_error), exp_e);
        chk({name, "_mute"}, int'(muting), exp_mute);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_settle(input string name, input logic [1:0] ch, input logic [11:0] d);
        for (int i = 0; i <= SET; i++)
            issue_check(name, ch, d, 2'b00, (i < SET) ? 0 : int'(d), 0, (i < SET) ? 1 : 0);
    endtask

    task automatic overrun_burst(input logic [11:0] base, output int n, output int last);
        @(negedge clk);
        bus.source_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(2'd2, base + 12'(k), 2'b00);
            @(negedge clk);
        end
        bus.source_ready = 1'b1;
        n = 0;
        last = -1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.source_valid) begin
                n++;
                last = int'(bus.source_data);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, last;
        model_reset();
        for (int c = 0; c < 4; c++) set_sink(2'(c), 1'b0, 12'h000, 2'b00);
        bus.source_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_valid", int'(bus.source_valid), 0);
        chk("rst_data", int'(bus.source_data), 0);
        chk("rst_sel", int'(active_sel), 0);
        chk("rst_mute", int'(muting), 1);
        chk("rst_ovr", int'(overrun_count), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // settle after reset on channel 0
        run_settle("s1", 2'd0, 12'h123);

        // debounced switch to highpass
        sel_async = 2'd2;
        repeat (60) @(negedge clk);
        chk("sw_sel", int'(active_sel), 2);
        chk("sw_mute", int'(muting), 1);
        run_settle("s2", 2'd2, 12'h2AB);

        // short glitch to channel 3 is discarded
        sel_async = 2'd3;
        issue_check("g1", 2'd2, 12'h301, 2'b00, 12'h301, 0, 0);
        issue_check("g2", 2'd2, 12'h302, 2'b00, 12'h302, 0, 0);
        sel_async = 2'd2;
        issue_check("g3", 2'd2, 12'h303, 2'b00, 12'h303, 0, 0);
        repeat (60) @(negedge clk);
        chk("g_sel", int'(active_sel), 2);
        chk("g_mute", int'(muting), 0);

        // overrun while DAC busy
        overrun_burst(12'h400, n, last);
        chk("ovr_count", int'(overrun_count), 2);
        chk("ovr_issues", n, 1);
        chk("ovr_last", last, 12'h402);
        for (int b = 0; b < 300; b++) overrun_burst(12'h500, n, last);
        chk("ovr_sat", int'(overrun_count), 255);

        // error sample is muted but its error code forwarded
        issue_check("e1", 2'd2, 12'h5A5, 2'b01, 0, 1, 0);
        issue_check("e2", 2'd2, 12'h3C3, 2'b00, 12'h3C3, 0, 0);

        // reset during an issue cycle
        sel_async = 2'd0;
        repeat (60) @(negedge clk);
        send(2'd0, 12'h111, 2'b00);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(bus.source_valid), 0);
        chk("mid_rst_data", int'(bus.source_data), 0);
        chk("mid_rst_sel", int'(active_sel), 0);
        chk("mid_rst_mute", int'(muting), 1);
        chk("mid_rst_ovr", int'(overrun_count), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run_settle("s6", 2'd0, 12'h123);

        // random traffic, model-checked every cycle
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            bus.source_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++)
                set_sink(2'(c), ($urandom_range(0, 5) == 0), 12'($urandom),
                         ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            if ($urandom_range(0, 149) == 0) sel_async = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        for (int c = 0; c < 4; c++) set_sink(2'(c), 1'b0, 12'h000, 2'b00);
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
